// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters between decode and writeback.
// Flags source hazards and counter overflow so decode holds until earlier writes retire.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic       pipe_stall,
  input  logic       flush,
  input  logic       in1_needed,
  input  logic       in2_needed,
  input  logic       in3_needed,
  input  logic       in4_needed,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  input  logic [2:0] in4,
  input  logic       ld_reg1,
  input  logic       ld_reg2,
  input  logic       ld_reg3,
  input  logic [2:0] dreg1,
  input  logic [2:0] dreg2,
  input  logic [2:0] dreg3,
  input  logic       wb_ld_reg1,
  input  logic       wb_ld_reg2,
  input  logic       wb_ld_reg3,
  input  logic [2:0] wb_dreg1,
  input  logic [2:0] wb_dreg2,
  input  logic [2:0] wb_dreg3,
  output logic       dep_stall,
  output logic       alloc_fire,
  output logic [7:0] busy_vec,
  output logic       wb_err
);

  localparam int SW = CNT_W + 3;
  localparam logic [SW-1:0] MAXV = SW'((2 ** CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       busy_q, busy_d;
  logic             wb_err_q, wb_err_d;

  logic [2:0] src   [4];
  logic [3:0] src_en;
  logic [2:0] dst   [3];
  logic [2:0] dst_en;
  logic [2:0] wbd   [3];
  logic [2:0] wbd_en;

  logic [1:0] inc [8];
  logic [1:0] dec [8];
  logic       haz, full;

  assign src    = '{in1, in2, in3, in4};
  assign src_en = {in4_needed, in3_needed, in2_needed, in1_needed};
  assign dst    = '{dreg1, dreg2, dreg3};
  assign dst_en = {ld_reg3, ld_reg2, ld_reg1};
  assign wbd    = '{wb_dreg1, wb_dreg2, wb_dreg3};
  assign wbd_en = {wb_ld_reg3, wb_ld_reg2, wb_ld_reg1};

  always_comb begin
    haz  = 1'b0;
    full = 1'b0;
    for (int r = 0; r < 8; r++) begin
      inc[r] = 2'd0;
      dec[r] = 2'd0;
      for (int j = 0; j < 3; j++) begin
        if (dst_en[j] && dst[j] == 3'(r)) inc[r] = inc[r] + 2'd1;
        if (wbd_en[j] && wbd[j] == 3'(r)) dec[r] = dec[r] + 2'd1;
      end
      // cnt + inc - dec > MAX, rearranged so nothing goes negative
      if (SW'(cnt_q[r]) + SW'(inc[r]) > MAXV + SW'(dec[r])) full = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (src_en[k] && cnt_q[src[k]] != '0) haz = 1'b1;
    end
  end

  assign dep_stall  = dec_valid & (haz | full);
  assign alloc_fire = dec_valid & ~dep_stall & ~pipe_stall & ~flush;

  always_comb begin
    logic [SW-1:0] avail;
    wb_err_d = wb_err_q;
    busy_d   = '0;
    avail    = '0;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = '0;
      if (!flush) begin
        avail = SW'(cnt_q[r]) + (alloc_fire ? SW'(inc[r]) : '0);
        if (SW'(dec[r]) > avail) begin
          wb_err_d = 1'b1;
        end else begin
          cnt_d[r] = CNT_W'(avail - SW'(dec[r]));
        end
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= '0;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, then random traffic
// checked against a counter-array model of the scoreboard rules.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n, dec_valid, pipe_stall, flush;
  logic       in1_needed, in2_needed, in3_needed, in4_needed;
  logic [2:0] in1, in2, in3, in4;
  logic       ld_reg1, ld_reg2, ld_reg3;
  logic [2:0] dreg1, dreg2, dreg3;
  logic       wb_ld_reg1, wb_ld_reg2, wb_ld_reg3;
  logic [2:0] wb_dreg1, wb_dreg2, wb_dreg3;
  logic       dep_stall, alloc_fire, wb_err;
  logic [7:0] busy_vec;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .pipe_stall(pipe_stall), .flush(flush),
    .in1_needed(in1_needed), .in2_needed(in2_needed), .in3_needed(in3_needed), .in4_needed(in4_needed),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .ld_reg1(ld_reg1), .ld_reg2(ld_reg2), .ld_reg3(ld_reg3),
    .dreg1(dreg1), .dreg2(dreg2), .dreg3(dreg3),
    .wb_ld_reg1(wb_ld_reg1), .wb_ld_reg2(wb_ld_reg2), .wb_ld_reg3(wb_ld_reg3),
    .wb_dreg1(wb_dreg1), .wb_dreg2(wb_dreg2), .wb_dreg3(wb_dreg3),
    .dep_stall(dep_stall), .alloc_fire(alloc_fire), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  typedef struct {
    logic       rst_n, dv, ps, fl;
    logic [3:0] need;   // bit k-1 = ink_needed
    logic [11:0] src;   // {in4,in3,in2,in1}
    logic [2:0] ld;     // {ld_reg3,ld_reg2,ld_reg1}
    logic [8:0] dreg;   // {dreg3,dreg2,dreg1}
    logic [2:0] wb;
    logic [8:0] wbd;
    logic       e_stall, e_fire;
    logic [7:0] e_busy;
    logic       e_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; dec_valid = v.dv; pipe_stall = v.ps; flush = v.fl;
    {in4_needed, in3_needed, in2_needed, in1_needed} = v.need;
    {in4, in3, in2, in1} = v.src;
    {ld_reg3, ld_reg2, ld_reg1} = v.ld;
    {dreg3, dreg2, dreg1} = v.dreg;
    {wb_ld_reg3, wb_ld_reg2, wb_ld_reg1} = v.wb;
    {wb_dreg3, wb_dreg2, wb_dreg1} = v.wbd;
  endtask

  function automatic vec_t mk(input logic r, input logic dv, input logic ps, input logic fl,
                              input logic [3:0] need, input logic [11:0] src,
                              input logic [2:0] ld, input logic [8:0] dreg,
                              input logic [2:0] wb, input logic [8:0] wbd,
                              input logic es, input logic ef, input logic [7:0] eb, input logic ee);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.ps = ps; v.fl = fl; v.need = need; v.src = src;
    v.ld = ld; v.dreg = dreg; v.wb = wb; v.wbd = wbd;
    v.e_stall = es; v.e_fire = ef; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  // behavioural model: a plain array of pending-write counts
  int m_cnt [8];
  int m_err;

  initial begin
    vec_t tbl [$];
    drive(mk(0,0,0,0, 4'h0,12'h0, 3'b000,9'h0, 3'b000,9'h0, 0,0,8'h00,0));
    @(posedge clk); @(posedge clk); #1;

    //          rst dv ps fl need  src                    ld      dreg                  wb      wbd                  stall fire busy  err
    tbl.push_back(mk(0,0,0,0, 4'h0, 12'h0,                3'b000, 9'h0,                 3'b000, 9'h0,                0,0, 8'h00,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b001, {3'd0,3'd0,3'd3},     3'b000, 9'h0,                0,1, 8'h08,0));
    tbl.push_back(mk(1,1,0,0, 4'h4, {3'd0,3'd3,3'd0,3'd0},3'b000, 9'h0,                 3'b000, 9'h0,                1,0, 8'h08,0));
    tbl.push_back(mk(1,0,0,0, 4'h0, 12'h0,                3'b000, 9'h0,                 3'b001, {3'd0,3'd0,3'd3},    0,0, 8'h00,0));
    tbl.push_back(mk(1,1,0,0, 4'h4, {3'd0,3'd3,3'd0,3'd0},3'b000, 9'h0,                 3'b000, 9'h0,                0,1, 8'h00,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b011, {3'd0,3'd4,3'd4},     3'b000, 9'h0,                0,1, 8'h10,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b011, {3'd0,3'd4,3'd4},     3'b000, 9'h0,                1,0, 8'h10,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b011, {3'd0,3'd4,3'd4},     3'b001, {3'd0,3'd0,3'd4},    0,1, 8'h10,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b111, {3'd5,3'd5,3'd0},     3'b000, 9'h0,                0,1, 8'h31,0));
    tbl.push_back(mk(1,1,0,1, 4'h0, 12'h0,                3'b001, {3'd0,3'd0,3'd6},     3'b001, {3'd0,3'd0,3'd0},    0,0, 8'h00,0));
    tbl.push_back(mk(1,0,0,0, 4'h0, 12'h0,                3'b000, 9'h0,                 3'b100, {3'd2,3'd0,3'd0},    0,0, 8'h00,1));
    tbl.push_back(mk(1,0,0,0, 4'h0, 12'h0,                3'b000, 9'h0,                 3'b000, 9'h0,                0,0, 8'h00,1));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b111, {3'd7,3'd7,3'd7},     3'b000, 9'h0,                0,1, 8'h80,1));
    tbl.push_back(mk(0,1,0,0, 4'h1, {3'd0,3'd0,3'd0,3'd7},3'b000, 9'h0,                 3'b000, 9'h0,                1,0, 8'h00,0));
    tbl.push_back(mk(1,1,0,0, 4'h1, {3'd0,3'd0,3'd0,3'd7},3'b000, 9'h0,                 3'b000, 9'h0,                0,1, 8'h00,0));
    tbl.push_back(mk(1,1,0,0, 4'h0, 12'h0,                3'b001, {3'd0,3'd0,3'd1},     3'b001, {3'd0,3'd0,3'd1},    0,1, 8'h00,0));
    tbl.push_back(mk(1,1,1,0, 4'h0, 12'h0,                3'b001, {3'd0,3'd0,3'd2},     3'b000, 9'h0,                0,0, 8'h00,0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("v%0d dep_stall", i), int'(dep_stall), int'(tbl[i].e_stall));
      chk($sformatf("v%0d alloc_fire", i), int'(alloc_fire), int'(tbl[i].e_fire));
      @(posedge clk); #1;
      chk($sformatf("v%0d busy_vec", i), int'(busy_vec), int'(tbl[i].e_busy));
      chk($sformatf("v%0d wb_err", i), int'(wb_err), int'(tbl[i].e_err));
    end

    // hold reset, then random traffic against the model
    drive(mk(0,0,0,0, 4'h0,12'h0, 3'b000,9'h0, 3'b000,9'h0, 0,0,8'h00,0));
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_err = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      int inc [8];
      int dec [8];
      int s [4];
      int d [3];
      int w [3];
      bit nd [4];
      bit l [3];
      bit wv [3];
      bit rn, dv, ps, fl, haz, full, e_stall, e_fire;
      int busy_exp;

      rn = ($urandom_range(59) != 0);
      dv = ($urandom_range(3) != 0);
      ps = ($urandom_range(5) == 0);
      fl = ($urandom_range(19) == 0);
      for (int k = 0; k < 4; k++) begin
        nd[k] = ($urandom_range(3) == 0);
        s[k] = $urandom_range(7);
      end
      for (int j = 0; j < 3; j++) begin
        l[j] = ($urandom_range(2) == 0);
        d[j] = $urandom_range(7);
        w[j] = $urandom_range(7);
        // retire mostly registers that actually have pending writes
        wv[j] = (m_cnt[w[j]] > 0) ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0);
      end

      rst_n = rn; dec_valid = dv; pipe_stall = ps; flush = fl;
      {in4_needed, in3_needed, in2_needed, in1_needed} = {nd[3], nd[2], nd[1], nd[0]};
      {in4, in3, in2, in1} = {3'(s[3]), 3'(s[2]), 3'(s[1]), 3'(s[0])};
      {ld_reg3, ld_reg2, ld_reg1} = {l[2], l[1], l[0]};
      {dreg3, dreg2, dreg1} = {3'(d[2]), 3'(d[1]), 3'(d[0])};
      {wb_ld_reg3, wb_ld_reg2, wb_ld_reg1} = {wv[2], wv[1], wv[0]};
      {wb_dreg3, wb_dreg2, wb_dreg1} = {3'(w[2]), 3'(w[1]), 3'(w[0])};

      for (int r = 0; r < 8; r++) begin inc[r] = 0; dec[r] = 0; end
      for (int j = 0; j < 3; j++) begin
        if (l[j]) inc[d[j]]++;
        if (wv[j]) dec[w[j]]++;
      end
      haz = 0; full = 0;
      for (int k = 0; k < 4; k++) if (nd[k] && m_cnt[s[k]] != 0) haz = 1;
      for (int r = 0; r < 8; r++) if (m_cnt[r] + inc[r] - dec[r] > 3) full = 1;
      e_stall = dv && (haz || full);
      e_fire = dv && !e_stall && !ps && !fl;

      #3;
      chk("rnd dep_stall", int'(dep_stall), int'(e_stall));
      chk("rnd alloc_fire", int'(alloc_fire), int'(e_fire));

      if (!rn) begin
        for (int r = 0; r < 8; r++) m_cnt[r] = 0;
        m_err = 0;
      end else if (fl) begin
        for (int r = 0; r < 8; r++) m_cnt[r] = 0;
      end else begin
        for (int r = 0; r < 8; r++) begin
          int v;
          v = m_cnt[r] + (e_fire ? inc[r] : 0) - dec[r];
          if (v < 0) begin v = 0; m_err = 1; end
          m_cnt[r] = v;
        end
      end
      busy_exp = 0;
      for (int r = 0; r < 8; r++) if (m_cnt[r] != 0) busy_exp |= (1 << r);

      @(posedge clk); #1;
      chk("rnd busy_vec", int'(busy_vec), busy_exp);
      chk("rnd wb_err", int'(wb_err), m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
